// File: rtl/gps_multi_rms_reporter.sv
`default_nettype none
// ============================================================================
// Module      : gps_multi_rms_reporter
// Description : Multi-channel RMS / GPS enquiry responder for the MCU UART
//               link. When an enquiry arrives, the block captures a fresh GPS
//               fix and/or N_CH RMS values, with a bounded wait for each. It
//               then streams one framed, checksummed reply byte by byte to the
//               shared UART transmitter.
//               Frame: START CMD LEN_L LEN_H STATUS YR MON DAY HR MIN SEC
//                      6x00 PAYLOAD CRC END
// Ports       : clk, rst (async, active-low)
//               enq_flag/enq_cmd      enquiry strobe and command
//               get_msg_ok + GPS time/position fields
//               rms_bus/rms_ok        N_CH packed RMS values and valid pulses
//               tx_idle               UART idle (falling edge = byte sent)
//               tx_data/start_tx      byte to send and 1-cycle send strobe
//               busy                  enquiry in progress (UART mux select)
//               done                  1-cycle pulse after END byte sent
//               enq_drop              1-cycle pulse: enquiry ignored while busy
// Revision    : 1.0 - initial release
// ============================================================================
module gps_multi_rms_reporter #(
    parameter int         N_CH        = 4,
    parameter int         RMS_W       = 16,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [7:0] START_CODE  = 8'hAA,
    parameter logic [7:0] END_CODE    = 8'h55,
    parameter logic [7:0] CMD_RMS     = 8'h21,
    parameter logic [7:0] CMD_GPS     = 8'h22,
    parameter logic [7:0] CMD_ALL     = 8'h23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_flag,
    input  logic [7:0]            enq_cmd,
    input  logic                  get_msg_ok,
    input  logic [7:0]            year,
    input  logic [7:0]            mon,
    input  logic [7:0]            day,
    input  logic [7:0]            hour,
    input  logic [7:0]            min,
    input  logic [7:0]            sec,
    input  logic [7:0]            latDu,
    input  logic [7:0]            latMin,
    input  logic [7:0]            longDu,
    input  logic [7:0]            longMin,
    input  logic [N_CH*RMS_W-1:0] rms_bus,
    input  logic [N_CH-1:0]       rms_ok,
    input  logic                  tx_idle,
    output logic [7:0]            tx_data,
    output logic                  start_tx,
    output logic                  busy,
    output logic                  done,
    output logic                  enq_drop
);

    // Timer counts 0 .. TIMEOUT_CYC-1, so each wait lasts TIMEOUT_CYC cycles.
    localparam int            TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TONE      = TW'(1);
    localparam logic [7:0]    RMS_BYTES = 8'(2 * N_CH);

    // GPS capture slots, in port order
    localparam int G_YR = 0, G_MON = 1, G_DAY = 2, G_HR = 3, G_MIN = 4, G_SEC = 5;
    localparam int G_LATD = 6, G_LATM = 7, G_LONGD = 8, G_LONGM = 9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_WAIT_RMS = 3'd2,
        S_WAIT_GPS = 3'd3,
        S_LOAD     = 3'd4,
        S_ISSUE    = 3'd5,
        S_WAIT_TX  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t          state, next_state;
    logic [7:0]      cmd_q;
    logic [1:0]      status;
    logic [15:0]     rms_cap [N_CH];
    logic [N_CH-1:0] rms_got;
    logic [7:0]      gps_cap [10];
    logic [TW-1:0]   timer;
    logic [7:0]      idx;
    logic [7:0]      crc;
    logic            sync1, sync2;

    logic [N_CH-1:0] rms_got_nxt;
    logic            all_rms;
    logic            timeout;
    logic            tx_done;
    logic            has_rms, has_gps;
    logic [7:0]      pay_len;
    logic [15:0]     frame_len;
    logic [7:0]      last_idx;
    logic [7:0]      pay_idx;
    logic [7:0]      gps_off;
    logic [7:0]      cur_byte;

    assign rms_got_nxt = rms_got | rms_ok;
    assign all_rms     = &rms_got_nxt;
    assign timeout     = (timer == TMAX);
    assign tx_done     = sync2 & ~sync1;
    assign has_rms     = (cmd_q == CMD_RMS) || (cmd_q == CMD_ALL);
    assign has_gps     = (cmd_q == CMD_GPS) || (cmd_q == CMD_ALL);
    assign pay_len     = (has_rms ? RMS_BYTES : 8'd0) + (has_gps ? 8'd4 : 8'd0);
    assign frame_len   = 16'd13 + {8'd0, pay_len};
    assign last_idx    = 8'd18 + pay_len;
    assign pay_idx     = idx - 8'd17;
    assign gps_off     = has_rms ? RMS_BYTES : 8'd0;

    // Byte selected by the frame index
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            8'd0:    cur_byte = START_CODE;
            8'd1:    cur_byte = cmd_q;
            8'd2:    cur_byte = frame_len[7:0];
            8'd3:    cur_byte = frame_len[15:8];
            8'd4:    cur_byte = {6'd0, status};
            8'd5:    cur_byte = gps_cap[G_YR];
            8'd6:    cur_byte = gps_cap[G_MON];
            8'd7:    cur_byte = gps_cap[G_DAY];
            8'd8:    cur_byte = gps_cap[G_HR];
            8'd9:    cur_byte = gps_cap[G_MIN];
            8'd10:   cur_byte = gps_cap[G_SEC];
            default: cur_byte = 8'h00;
        endcase
        if (idx >= 8'd17 && idx < last_idx - 8'd1) begin
            for (int k = 0; k < N_CH; k++) begin
                if (has_rms && pay_idx == 8'(2 * k))     cur_byte = rms_cap[k][7:0];
                if (has_rms && pay_idx == 8'(2 * k + 1)) cur_byte = rms_cap[k][15:8];
            end
            if (has_gps && pay_idx == gps_off)         cur_byte = gps_cap[G_LONGD];
            if (has_gps && pay_idx == gps_off + 8'd1)  cur_byte = gps_cap[G_LONGM];
            if (has_gps && pay_idx == gps_off + 8'd2)  cur_byte = gps_cap[G_LATD];
            if (has_gps && pay_idx == gps_off + 8'd3)  cur_byte = gps_cap[G_LATM];
        end
        if (idx == last_idx - 8'd1) cur_byte = ~crc;
        if (idx == last_idx)        cur_byte = END_CODE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (enq_flag && !busy) next_state = S_DECODE;
            S_DECODE: begin
                if (cmd_q == CMD_RMS || cmd_q == CMD_ALL) next_state = S_WAIT_RMS;
                else if (cmd_q == CMD_GPS)                next_state = S_WAIT_GPS;
                else                                      next_state = S_IDLE;
            end
            S_WAIT_RMS: if (all_rms || timeout)    next_state = S_WAIT_GPS;
            S_WAIT_GPS: if (get_msg_ok || timeout) next_state = S_LOAD;
            S_LOAD:     next_state = S_ISSUE;
            S_ISSUE:    next_state = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_done) next_state = (idx == last_idx) ? S_DONE : S_ISSUE;
            end
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data  <= 8'h00;
            start_tx <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            enq_drop <= 1'b0;
            cmd_q    <= 8'h00;
            status   <= 2'b00;
            rms_got  <= '0;
            timer    <= '0;
            idx      <= 8'h00;
            crc      <= 8'h00;
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            for (int k = 0; k < N_CH; k++) rms_cap[k] <= 16'h0000;
            for (int g = 0; g < 10; g++)   gps_cap[g] <= 8'h00;
        end else begin
            start_tx <= 1'b0;
            done     <= 1'b0;
            enq_drop <= enq_flag & busy;
            sync1    <= tx_idle;
            sync2    <= sync1;
            // Restart the timer whenever a wait state is entered or left
            timer    <= ((state == S_WAIT_RMS || state == S_WAIT_GPS) && next_state == state)
                        ? timer + TONE : '0;
            case (state)
                S_IDLE: begin
                    if (enq_flag && !busy) begin
                        // Fresh capture per enquiry: anything not captured reads as zero
                        cmd_q   <= enq_cmd;
                        busy    <= 1'b1;
                        status  <= 2'b00;
                        rms_got <= '0;
                        for (int k = 0; k < N_CH; k++) rms_cap[k] <= 16'h0000;
                        for (int g = 0; g < 10; g++)   gps_cap[g] <= 8'h00;
                    end else begin
                        // Unknown commands land here with busy still set
                        busy <= 1'b0;
                    end
                end
                S_WAIT_RMS: begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (rms_ok[k]) rms_cap[k] <= 16'(rms_bus[k*RMS_W +: RMS_W]);
                    end
                    rms_got <= rms_got_nxt;
                    if (!all_rms && timeout) status[0] <= 1'b1;
                end
                S_WAIT_GPS: begin
                    if (get_msg_ok) begin
                        gps_cap[G_YR]    <= year;
                        gps_cap[G_MON]   <= mon;
                        gps_cap[G_DAY]   <= day;
                        gps_cap[G_HR]    <= hour;
                        gps_cap[G_MIN]   <= min;
                        gps_cap[G_SEC]   <= sec;
                        gps_cap[G_LATD]  <= latDu;
                        gps_cap[G_LATM]  <= latMin;
                        gps_cap[G_LONGD] <= longDu;
                        gps_cap[G_LONGM] <= longMin;
                    end else if (timeout) begin
                        status[1] <= 1'b1;
                    end
                end
                S_LOAD: begin
                    idx <= 8'h00;
                    crc <= 8'h00;
                end
                S_ISSUE: begin
                    tx_data  <= cur_byte;
                    start_tx <= 1'b1;
                    if (idx >= 8'd1 && idx <= last_idx - 8'd2) crc <= crc + cur_byte;
                end
                S_WAIT_TX: begin
                    if (tx_done && idx != last_idx) idx <= idx + 8'd1;
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gps_multi_rms_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gps_multi_rms_reporter
// Description : Self-checking bench for gps_multi_rms_reporter. A simple UART
//               responder collects the transmitted bytes; a frame model built
//               from the enquiry contents gives the expected reply.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gps_multi_rms_reporter;
    localparam int         N_CH    = 4;
    localparam int         RMS_W   = 16;
    localparam int         TOUT    = 100;
    localparam logic [7:0] CMD_RMS = 8'h21;
    localparam logic [7:0] CMD_GPS = 8'h22;
    localparam logic [7:0] CMD_ALL = 8'h23;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enq_flag = 1'b0;
    logic [7:0] enq_cmd = 8'h00;
    logic get_msg_ok = 1'b0;
    logic [7:0] year = 0, mon = 0, day = 0, hour = 0, min = 0, sec = 0;
    logic [7:0] latDu = 0, latMin = 0, longDu = 0, longMin = 0;
    logic [N_CH*RMS_W-1:0] rms_bus = '0;
    logic [N_CH-1:0] rms_ok = '0;
    logic tx_idle = 1'b1;
    logic [7:0] tx_data;
    logic start_tx, busy, done, enq_drop;

    gps_multi_rms_reporter #(.N_CH(N_CH), .RMS_W(RMS_W), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst(rst), .enq_flag(enq_flag), .enq_cmd(enq_cmd),
        .get_msg_ok(get_msg_ok), .year(year), .mon(mon), .day(day), .hour(hour),
        .min(min), .sec(sec), .latDu(latDu), .latMin(latMin), .longDu(longDu),
        .longMin(longMin), .rms_bus(rms_bus), .rms_ok(rms_ok), .tx_idle(tx_idle),
        .tx_data(tx_data), .start_tx(start_tx), .busy(busy), .done(done),
        .enq_drop(enq_drop)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0, drop_cnt = 0, stx_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [15:0] rms_val [N_CH];
    logic [7:0]  gps_val [10];   // yr mon day hr min sec latDu latMin longDu longMin

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1)     done_cnt++;
        if (enq_drop === 1'b1) drop_cnt++;
        if (start_tx === 1'b1) stx_cnt++;
    end

    // UART stand-in: accepts a byte, then signals it sent by a tx_idle low pulse
    initial begin
        forever begin
            @(negedge clk);
            if (start_tx === 1'b1) begin
                rx_q.push_back(tx_data);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                tx_idle = 1'b0;
                @(negedge clk);
                tx_idle = 1'b1;
            end
        end
    end

    task automatic drive_gps(input bit use_real);
        if (use_real) begin
            year = gps_val[0]; mon = gps_val[1]; day = gps_val[2];
            hour = gps_val[3]; min = gps_val[4]; sec = gps_val[5];
            latDu = gps_val[6]; latMin = gps_val[7]; longDu = gps_val[8]; longMin = gps_val[9];
        end else begin
            year = 8'($urandom); mon = 8'($urandom); day = 8'($urandom);
            hour = 8'($urandom); min = 8'($urandom); sec = 8'($urandom);
            latDu = 8'($urandom); latMin = 8'($urandom);
            longDu = 8'($urandom); longMin = 8'($urandom);
        end
    endtask

    task automatic pulse_gps(input bit use_real);
        drive_gps(use_real);
        get_msg_ok = 1'b1;
        @(negedge clk);
        get_msg_ok = 1'b0;
        drive_gps(1'b0);
    endtask

    task automatic pulse_rms(input logic [N_CH-1:0] m);
        for (int k = 0; k < N_CH; k++)
            rms_bus[k*RMS_W +: RMS_W] = m[k] ? rms_val[k] : 16'($urandom);
        rms_ok = m;
        @(negedge clk);
        rms_ok = '0;
        for (int k = 0; k < N_CH; k++) rms_bus[k*RMS_W +: RMS_W] = 16'($urandom);
    endtask

    task automatic randomize_values();
        for (int k = 0; k < N_CH; k++) rms_val[k] = 16'($urandom);
        for (int g = 0; g < 10; g++)   gps_val[g] = 8'($urandom);
    endtask

    // Reference frame from the enquiry contents
    task automatic build_expected(input logic [7:0] cmd, input logic [N_CH-1:0] mask,
                                  input bit gps_on);
        bit has_rms, has_gps, rms_to;
        int p, len;
        logic [7:0] sum;
        logic [15:0] v;
        has_rms = (cmd == CMD_RMS) || (cmd == CMD_ALL);
        has_gps = (cmd == CMD_GPS) || (cmd == CMD_ALL);
        rms_to  = has_rms && (mask != '1);
        p   = (has_rms ? 2 * N_CH : 0) + (has_gps ? 4 : 0);
        len = 13 + p;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(cmd);
        exp_q.push_back(8'(len % 256));
        exp_q.push_back(8'(len / 256));
        exp_q.push_back({6'd0, !gps_on, rms_to});
        for (int g = 0; g < 6; g++) exp_q.push_back(gps_on ? gps_val[g] : 8'h00);
        for (int z = 0; z < 6; z++) exp_q.push_back(8'h00);
        if (has_rms) begin
            for (int k = 0; k < N_CH; k++) begin
                v = mask[k] ? rms_val[k] : 16'h0000;
                exp_q.push_back(v[7:0]);
                exp_q.push_back(v[15:8]);
            end
        end
        if (has_gps) begin
            exp_q.push_back(gps_on ? gps_val[8] : 8'h00);
            exp_q.push_back(gps_on ? gps_val[9] : 8'h00);
            exp_q.push_back(gps_on ? gps_val[6] : 8'h00);
            exp_q.push_back(gps_on ? gps_val[7] : 8'h00);
        end
        sum = 8'h00;
        for (int i = 1; i < exp_q.size(); i++) sum = sum + exp_q[i];
        exp_q.push_back(~sum);
        exp_q.push_back(8'h55);
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [31:0] obs;
        check({tag, "_len"}, rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (base + i < rx_q.size()) ? {24'd0, rx_q[base + i]} : 32'hFFFF_FFFF;
            check($sformatf("%s_b%0d", tag, i), obs, {24'd0, exp_q[i]});
        end
    endtask

    task automatic send_enq(input logic [7:0] cmd);
        enq_cmd  = cmd;
        enq_flag = 1'b1;
        @(negedge clk);
        enq_flag = 1'b0;
        enq_cmd  = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [N_CH-1:0] mask,
                             input bit gps_on, input bit poke, input string tag);
        int rx_base, d_base, dr_base;
        bit poked, has_rms;
        has_rms = (cmd == CMD_RMS) || (cmd == CMD_ALL);
        pulse_gps(1'b0);                       // stray fix while idle: ignored
        rx_base = rx_q.size();
        d_base  = done_cnt;
        dr_base = drop_cnt;
        send_enq(cmd);
        check({tag, "_busy_set"}, busy, 1);
        repeat (3) @(negedge clk);
        if (has_rms) begin
            pulse_gps(1'b0);                   // fix during RMS wait: ignored
            pulse_rms(mask & 4'b0011);         // two channels at once
            pulse_rms(mask & 4'b0100);
            pulse_rms(mask & 4'b1000);
            if (mask != '1) begin
                repeat (80) @(negedge clk);
                pulse_gps(1'b0);               // still before the RMS timeout
                repeat (TOUT - 70) @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
            for (int k = 0; k < N_CH; k++) rms_val[k] = rms_val[k];
            rms_bus = {N_CH{16'($urandom)}};
            rms_ok  = '1;                      // RMS pulses in GPS wait: ignored
            @(negedge clk);
            rms_ok  = '0;
        end
        repeat (2) @(negedge clk);
        if (gps_on) pulse_gps(1'b1);
        else        repeat (TOUT + 10) @(negedge clk);
        build_expected(cmd, mask, gps_on);
        poked = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (done_cnt != d_base) break;
            @(negedge clk);
            if (enq_flag) enq_flag = 1'b0;
            if (poke && !poked && (rx_q.size() - rx_base) >= 5) begin
                enq_cmd  = CMD_GPS;
                enq_flag = 1'b1;
                poked    = 1'b1;
            end
        end
        enq_flag = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt - d_base, 1);
        check({tag, "_busy_clr"}, busy, 0);
        check({tag, "_drop_cnt"}, drop_cnt - dr_base, poke ? 1 : 0);
        check_frame(tag, rx_base);
    endtask

    initial begin
        int base, busy_hi, d_base, s_base;
        logic [7:0] cmd;
        logic [N_CH-1:0] mask;
        bit gps_on;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 0);
        check("rst_start_tx", start_tx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enq_drop", enq_drop, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // RMS frame with fixed channel values
        randomize_values();
        rms_val[0] = 16'h1111; rms_val[1] = 16'h2222; rms_val[2] = 16'h3333; rms_val[3] = 16'h4444;
        run_frame(CMD_RMS, 4'hF, 1'b1, 1'b0, "rms_dir");

        // GPS frame with fixed position; enquiry during transmission is dropped
        randomize_values();
        gps_val[8] = 8'd114; gps_val[9] = 8'd30; gps_val[6] = 8'd22; gps_val[7] = 8'd45;
        run_frame(CMD_GPS, 4'hF, 1'b1, 1'b1, "gps_dir");

        // Combined frame, channel 2 never reports
        randomize_values();
        run_frame(CMD_ALL, 4'b1011, 1'b1, 1'b0, "all_rms_to");

        // Combined frame, GPS never reports
        randomize_values();
        run_frame(CMD_ALL, 4'hF, 1'b0, 1'b0, "all_gps_to");

        // Unknown command: short busy, no frame, no done
        d_base = done_cnt;
        s_base = stx_cnt;
        send_enq(8'h99);
        busy_hi = 0;
        for (int n = 0; n < 8; n++) begin
            if (busy === 1'b1) busy_hi++;
            @(negedge clk);
        end
        check("bad_busy_cycles", busy_hi, 2);
        check("bad_start_tx", stx_cnt - s_base, 0);
        check("bad_done", done_cnt - d_base, 0);

        // Reset in the middle of a frame
        for (int g = 0; g < 10; g++) gps_val[g] = 8'(g + 1);
        base = rx_q.size();
        send_enq(CMD_GPS);
        repeat (3) @(negedge clk);
        pulse_gps(1'b1);
        for (int n = 0; n < 2000; n++) begin
            if (rx_q.size() - base >= 10) break;
            @(negedge clk);
        end
        check("mid_reached_b10", rx_q.size() - base >= 10, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_start_tx", start_tx, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_enq_drop", enq_drop, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", busy, 0);
        randomize_values();
        gps_val[8] = 8'd114; gps_val[9] = 8'd30; gps_val[6] = 8'd22; gps_val[7] = 8'd45;
        run_frame(CMD_GPS, 4'hF, 1'b1, 1'b0, "post_rst_gps");

        // Randomized enquiries
        for (int it = 0; it < 6; it++) begin
            randomize_values();
            case ($urandom_range(0, 2))
                0:       cmd = CMD_RMS;
                1:       cmd = CMD_GPS;
                default: cmd = CMD_ALL;
            endcase
            mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            gps_on = ($urandom_range(0, 4) != 0);
            run_frame(cmd, mask, gps_on, (it == 2), $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
